// File: rtl/fetch_unit.sv
// Instruction fetch front end: walks the PC, waits on memory, hands one
// instruction at a time to decode and resolves conditional branches on accept.
module fetch_unit #(
  parameter logic [11:0] RESET_VECTOR = 12'h000,
  parameter int unsigned MEM_WAIT     = 1
) (
  input  logic        iClk,
  input  logic        iReset_n,
  input  logic        iRun,
  output logic [11:0] oPcAddress,
  input  logic [31:0] iInstr,
  output logic [31:0] oInstr,
  output logic        oInstrValid,
  input  logic        iInstrReady,
  input  logic        iBranchEn,
  input  logic [2:0]  iBranchCond,
  input  logic [11:0] iBranchTarget,
  input  logic [4:0]  iPSR,
  input  logic        iHalt,
  output logic        oHalted,
  output logic [15:0] oFetchCount
);

  localparam int unsigned PC_W    = 12;
  localparam int unsigned CNT_W   = 4;
  localparam int unsigned INSTR_W = 32;
  localparam int unsigned COUNT_W = 16;
  localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(MEM_WAIT);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_VALID, S_HALT} state_t;

  state_t               state_q, state_d;
  logic [PC_W-1:0]      pc_q, pc_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [INSTR_W-1:0]   instr_q, instr_d;
  logic                 valid_q, valid_d;
  logic                 halted_q, halted_d;
  logic [COUNT_W-1:0]   count_q, count_d;
  logic                 cond_true_c;

  // Branch condition decode against the status flags
  always_comb begin
    cond_true_c = 1'b0;
    case (iBranchCond)
      3'd0:    cond_true_c = 1'b1;
      3'd1:    cond_true_c = iPSR[0];
      3'd2:    cond_true_c = iPSR[1];
      3'd3:    cond_true_c = iPSR[2];
      3'd4:    cond_true_c = iPSR[3];
      3'd5:    cond_true_c = iPSR[4];
      3'd6:    cond_true_c = ~iPSR[3];
      default: cond_true_c = 1'b0;
    endcase
  end

  // Next-state and next-output logic
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    cnt_d    = cnt_q;
    instr_d  = instr_q;
    valid_d  = valid_q;
    halted_d = halted_q;
    count_d  = count_q;
    case (state_q)
      S_IDLE: begin
        if (iHalt) begin
          state_d  = S_HALT;
          halted_d = 1'b1;
        end else if (iRun) begin
          state_d = S_WAIT;
          cnt_d   = WAIT_LOAD;
        end
      end
      S_WAIT: begin
        if (iHalt) begin
          state_d  = S_HALT;
          halted_d = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
          // Capture when the counter reads 1 (<= guards an illegal MEM_WAIT of 0)
          if (cnt_q <= CNT_W'(1)) begin
            instr_d = iInstr;
            valid_d = 1'b1;
            state_d = S_VALID;
          end
        end
      end
      S_VALID: begin
        if (iInstrReady) begin
          valid_d = 1'b0;
          pc_d    = (iBranchEn && cond_true_c) ? iBranchTarget : pc_q + PC_W'(1);
          count_d = (count_q == {COUNT_W{1'b1}}) ? count_q : count_q + COUNT_W'(1);
          if (iHalt) begin
            state_d  = S_HALT;
            halted_d = 1'b1;
          end else begin
            state_d = S_WAIT;
            cnt_d   = WAIT_LOAD;
          end
        end
      end
      S_HALT: begin
        valid_d  = 1'b0;
        halted_d = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) begin
      state_q  <= S_IDLE;
      pc_q     <= RESET_VECTOR;
      cnt_q    <= '0;
      instr_q  <= '0;
      valid_q  <= 1'b0;
      halted_q <= 1'b0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      cnt_q    <= cnt_d;
      instr_q  <= instr_d;
      valid_q  <= valid_d;
      halted_q <= halted_d;
      count_q  <= count_d;
    end
  end

  assign oPcAddress  = pc_q;
  assign oInstr      = instr_q;
  assign oInstrValid = valid_q;
  assign oHalted     = halted_q;
  assign oFetchCount = count_q;

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The block SHALL have parameter RESET_VECTOR, default 12'h000, giving the PC value loaded at reset.
REQ-002 The block SHALL have parameter MEM_WAIT, default 1, giving the memory read wait in cycles (legal range 1..15).
REQ-003 The block SHALL have port iClk, input, 1 bit: the single clock; all state changes occur on its rising edge.
REQ-004 The block SHALL have port iReset_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The block SHALL have port iRun, input, 1 bit: starts fetching from IDLE.
REQ-006 The block SHALL have port oPcAddress, output, 12 bits: instruction address driven to the memory PC read port.
REQ-007 The block SHALL have port iInstr, input, 32 bits: instruction word returned by memory.
REQ-008 The block SHALL have port oInstr, output, 32 bits: captured instruction presented to decode.
REQ-009 The block SHALL have port oInstrValid, output, 1 bit: oInstr is valid.
REQ-010 The block SHALL have port iInstrReady, input, 1 bit: decode accepts oInstr.
REQ-011 The block SHALL have port iBranchEn, input, 1 bit: the accepted instruction requests a branch.
REQ-012 The block SHALL have port iBranchCond, input, 3 bits: branch condition select.
REQ-013 The block SHALL have port iBranchTarget, input, 12 bits: branch destination address.
REQ-014 The block SHALL have port iPSR, input, 5 bits: status flags, bit0 carry, bit1 even, bit2 odd parity, bit3 zero, bit4 negative.
REQ-015 The block SHALL have port iHalt, input, 1 bit: stop-fetch request.
REQ-016 The block SHALL have port oHalted, output, 1 bit: the block is in HALT.
REQ-017 The block SHALL have port oFetchCount, output, 16 bits: count of accepted instructions.

Function
REQ-018 The block SHALL implement four states: IDLE, WAIT, VALID, HALT.
REQ-019 oPcAddress SHALL equal the PC register at all times.
REQ-020 In IDLE, iRun=1 SHALL move the block to WAIT and load the wait counter with MEM_WAIT.
REQ-021 In WAIT, the counter SHALL decrement each cycle; in the cycle it reads 1, the block SHALL capture iInstr into oInstr, set oInstrValid=1 and enter VALID, so that oInstrValid rises exactly MEM_WAIT cycles after WAIT entry.
REQ-022 In VALID, oInstr and oInstrValid SHALL stay stable until a cycle with iInstrReady=1 (the accept).
REQ-023 On accept, the PC SHALL load iBranchTarget if iBranchEn=1 and the condition holds; otherwise it SHALL load PC+1, wrapping 12'hFFF to 12'h000.
REQ-024 iBranchEn, iBranchCond and iPSR SHALL be sampled only in the accept cycle.
REQ-025 Conditions SHALL be: 0 always, 1 carry, 2 even, 3 odd parity, 4 zero, 5 negative, 6 not-zero, 7 never.
REQ-026 On accept, oInstrValid SHALL clear and the block SHALL re-enter WAIT with the counter reloaded, unless iHalt=1, in which case it SHALL enter HALT.
REQ-027 On accept, oFetchCount SHALL increment and saturate at 16'hFFFF.
REQ-028 iHalt=1 in IDLE or WAIT SHALL move the block to HALT next cycle without asserting oInstrValid; the PC SHALL be unchanged.
REQ-029 iHalt=1 in VALID without iInstrReady SHALL have no effect; the pending instruction SHALL still be delivered.
REQ-030 In HALT, oHalted SHALL be 1 and oInstrValid 0; HALT SHALL be exited only by reset.
REQ-031 iRun SHALL be ignored outside IDLE.

Reset
REQ-032 iReset_n=0 SHALL immediately, regardless of iClk, force: state IDLE, PC=RESET_VECTOR, oInstr=32'h0, oInstrValid=0, oHalted=0, oFetchCount=0, wait counter=0.
REQ-033 Reset asserted mid-WAIT or mid-VALID SHALL discard the pending instruction and SHALL NOT increment oFetchCount.
REQ-034 After release, the block SHALL remain in IDLE until iRun=1.

Verification
REQ-035 Sequential fetch: MEM_WAIT=2, memory[0..2]=A,B,C, iInstrReady=1, iRun pulse -> oInstr A, B, C each valid 2 cycles after its WAIT entry; oPcAddress 0,1,2,3; oFetchCount=3.
REQ-036 Backpressure: iInstrReady=0 for 5 cycles in VALID -> oInstr and oInstrValid held; PC does not advance; count is unchanged until ready.
REQ-037 Branch: at PC=12'h010, iBranchEn=1, iBranchCond=4 -> with iPSR[3]=1, next oPcAddress=iBranchTarget=12'h200; with iPSR[3]=0, next oPcAddress=12'h011; with cond=7, next oPcAddress=12'h011.
REQ-038 Wrap: PC=12'hFFF accepted without branch -> oPcAddress=12'h000.
REQ-039 Halt: iHalt=1 during WAIT -> oHalted=1 next cycle, no valid pulse; iHalt=1 with VALID held -> instruction delivered on ready, then HALT.
REQ-040 Async reset: iReset_n low between edges during VALID -> oInstrValid=0 and oPcAddress=RESET_VECTOR before the next edge; oFetchCount=0.
